// File: rtl/csa_resolve_if.sv
// Handshake bundle for csa_resolve: operand pair in, resolved binary result out.
interface csa_resolve_if #(
   parameter int N = 15
);
   logic         in_valid;
   logic         in_ready;
   logic [N:0]   sum_in;
   logic [N:0]   carry_in;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [N+1:0] result;

   modport master (
      output in_valid, sum_in, carry_in, cin, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, sum_in, carry_in, cin, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/csa_resolve.sv
// Sequential carry-propagate resolver: adds a carry-save (sum, carry) pair
// CHUNK bits per clock, least-significant chunk first.
module csa_resolve #(
   parameter int N     = 15,
   parameter int CHUNK = 4
) (
   input logic          clk,
   input logic          rst,
   csa_resolve_if.slave bus
);
   localparam int NCH  = (N + 1) / CHUNK;
   localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCH - 1);

   generate
      if ((N + 1) % CHUNK != 0) begin : g_chunk_check
         $error("csa_resolve: N+1 must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [N:0]      r_a;
   logic [N:0]      r_b;
   logic            r_carry;
   logic [IDXW-1:0] r_idx;
   logic [N+1:0]    r_result;
   logic            r_out_valid;
   logic [CHUNK:0]  w_s;

   assign w_s = (CHUNK+1)'(r_a[CHUNK-1:0]) + (CHUNK+1)'(r_b[CHUNK-1:0])
              + (CHUNK+1)'(r_carry);

   // in_ready is held low combinationally while reset is asserted
   assign bus.in_ready  = ~rst & (r_state == S_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.sum_in;
                  r_b     <= bus.carry_in;
                  r_carry <= bus.cin;
                  r_idx   <= '0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_result[r_idx*CHUNK +: CHUNK] <= w_s[CHUNK-1:0];
               r_carry <= w_s[CHUNK];
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == IDX_LAST) begin
                  r_result[N+1] <= w_s[CHUNK];
                  r_out_valid   <= 1'b1;
                  r_state       <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_csa_resolve.sv
// Scoreboard bench for csa_resolve at N=15, CHUNK=4.
module tb_csa_resolve;
   localparam int N     = 15;
   localparam int CHUNK = 4;
   localparam int NCH   = (N + 1) / CHUNK;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [N+1:0] sb[$];

   csa_resolve_if #(.N(N)) bus ();

   csa_resolve #(.N(N), .CHUNK(CHUNK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one operand triple from a negedge, wait (bounded) for acceptance,
   // push the expected result, and return at the negedge after the accept edge.
   task automatic send(input logic [N:0] s, input logic [N:0] c, input logic ci,
                       output bit ok);
      int guard;
      bus.in_valid = 1'b1;
      bus.sum_in   = s;
      bus.carry_in = c;
      bus.cin      = ci;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      ok = bus.in_ready;
      if (ok) begin
         sb.push_back((N+2)'(s) + (N+2)'(c) + (N+2)'(ci));
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cycles);
      cycles = 0;
      while (!bus.out_valid && cycles < 50) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.sum_in = '0; bus.carry_in = '0; bus.cin = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== '0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b result=%0h, required 0 0 0",
                  bus.in_ready, bus.out_valid, bus.result);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b required 1", bus.in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [N:0] s_tab [4] = '{16'd10, 16'hFFFF, 16'h000F, 16'h0FFF};
      logic [N:0] c_tab [4] = '{16'd0,  16'hFFFF, 16'h0001, 16'h0001};
      logic       ci_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [N+1:0] exp_tab[4] = '{17'd10, 17'h1FFFF, 17'h00010, 17'h01000};
      logic [N+1:0] exp;
      bit ok;
      int cyc;
      for (int i = 0; i < 4; i++) begin
         send(s_tab[i], c_tab[i], ci_tab[i], ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL basic_accept[%0d]: in_ready never high", i);
            continue;
         end
         wait_out(cyc);
         checks++;
         if (cyc !== NCH) begin
            errors++;
            $display("FAIL basic_latency[%0d]: got %0d cycles required %0d", i, cyc, NCH);
         end
         exp = sb.pop_front();
         checks++;
         if (bus.result !== exp || exp !== exp_tab[i]) begin
            errors++;
            $display("FAIL basic_result[%0d]: got %0h required %0h", i, bus.result, exp_tab[i]);
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake[%0d]: out_valid=%b in_ready=%b required 0 1",
                     i, bus.out_valid, bus.in_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [N+1:0] exp;
      bit ok;
      int cyc;
      send(16'd3, 16'd4, 1'b0, ok);
      wait_out(cyc);
      checks++;
      if (!ok || cyc >= 50) begin
         errors++;
         $display("FAIL bp_first: accept=%0b cycles=%0d", ok, cyc);
      end
      exp = sb.pop_front();
      // second producer request arrives while the first result is stalled
      bus.in_valid = 1'b1; bus.sum_in = 16'd5; bus.carry_in = 16'd6; bus.cin = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.result !== exp || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: out_valid=%b result=%0h in_ready=%b required 1 %0h 0",
                     k, bus.out_valid, bus.result, bus.in_ready, exp);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== exp) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b result=%0h required 0 1 %0h",
                  bus.out_valid, bus.in_ready, bus.result, exp);
      end
      sb.push_back(17'd12);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_out(cyc);
      exp = sb.pop_front();
      checks++;
      if (cyc !== NCH || bus.result !== exp) begin
         errors++;
         $display("FAIL bp_second: cycles=%0d result=%0h required %0d %0h",
                  cyc, bus.result, NCH, exp);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [N+1:0] exp;
      bit ok;
      int cyc;
      send(16'd100, 16'd200, 1'b0, ok);
      sb.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async: out_valid=%b result=%0h in_ready=%b required 0 0 0",
                  bus.out_valid, bus.result, bus.in_ready);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_hold[%0d]: out_valid=%b in_ready=%b required 0 0",
                     k, bus.out_valid, bus.in_ready);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_release: in_ready=%b out_valid=%b required 1 0",
                  bus.in_ready, bus.out_valid);
      end
      send(16'd7, 16'd9, 1'b1, ok);
      wait_out(cyc);
      exp = sb.pop_front();
      checks++;
      if (!ok || cyc !== NCH || bus.result !== exp || exp !== 17'd17) begin
         errors++;
         $display("FAIL rst_mid_next: cycles=%0d result=%0h required %0d 11",
                  cyc, bus.result, NCH);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      int n;
      int last;
      int got;
      int t;
      int guard;
      logic [N+1:0] exp;
      bus.out_ready = 1'b1;
      n = 0;
      last = 0;
      fork
         begin
            for (int i = 0; i < 50; i++) begin
               bus.in_valid = 1'b1;
               bus.sum_in   = N'($urandom_range(0, 65535));
               bus.carry_in = N'($urandom_range(0, 65535));
               bus.cin      = 1'($urandom_range(0, 1));
               guard = 0;
               while (!bus.in_ready && guard < 100) begin
                  @(negedge clk);
                  n++;
                  guard++;
               end
               if (guard >= 100) begin
                  checks++;
                  errors++;
                  $display("FAIL b2b_accept[%0d]: no accept within bound", i);
                  break;
               end
               sb.push_back((N+2)'(bus.sum_in) + (N+2)'(bus.carry_in) + (N+2)'(bus.cin));
               if (i > 0) begin
                  checks++;
                  if (n - last !== NCH + 2) begin
                     errors++;
                     $display("FAIL b2b_period[%0d]: got %0d cycles required %0d",
                              i, n - last, NCH + 2);
                  end
               end
               last = n;
               @(negedge clk);
               n++;
            end
            bus.in_valid = 1'b0;
         end
         begin
            got = 0;
            t = 0;
            while (got < 50 && t < 1000) begin
               @(negedge clk);
               t++;
               if (bus.out_valid) begin
                  checks++;
                  if (sb.size() == 0) begin
                     errors++;
                     $display("FAIL b2b_result[%0d]: unexpected output %0h", got, bus.result);
                  end else begin
                     exp = sb.pop_front();
                     if (bus.result !== exp) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got %0h required %0h",
                                 got, bus.result, exp);
                     end
                  end
                  got++;
               end
            end
            if (got < 50) begin
               checks++;
               errors++;
               $display("FAIL b2b_timeout: got %0d results required 50", got);
            end
         end
      join
      bus.out_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/csa_resolve.md
Name: csa_resolve

Overview:
Sequential carry-propagate resolver that converts the redundant (sum, carry) pair from a carry-save stage into a single binary result.
Adds CHUNK bits per clock, least-significant chunk first, and carries the chunk carry between cycles.
Sits downstream of the carry-save adder tree. Uses a valid/ready handshake on both input and output.

Parameters:
N, 15, carry-save stage operand width; sum_in/carry_in are N+1 bits wide.
CHUNK, 4, bits resolved per cycle; (N+1) % CHUNK must be 0, otherwise elaboration error.
NCH, (N+1)/CHUNK, derived localparam: number of BUSY cycles (default 4).

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand pair present.
in_ready  out  1  block can accept operands.
sum_in  in  N+1  sum vector; bit i has weight 2^i.
carry_in  in  N+1  carry vector, already aligned; bit i has weight 2^i.
cin  in  1  carry-in, weight 2^0.
out_valid  out  1  result available.
out_ready  in  1  downstream accepts result.
result  out  N+2  sum_in + carry_in + cin, full width, no overflow possible.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state = IDLE, out_valid = 0, result = 0, internal carry = 0, chunk index = 0.
- in_ready = 0 while rst is high; afterwards in_ready = (state == IDLE).
- States: IDLE, BUSY, DONE. Two-bit encoding; encoding is free.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready at an edge: capture sum_in and carry_in into operand shift registers, set carry = cin, set idx = 0, go to BUSY.
  - Inputs need not be held after the accept edge.
- BUSY:
  - in_ready = 0.
  - Each edge: s = A[CHUNK-1:0] + B[CHUNK-1:0] + carry (CHUNK+1 bits).
  - Write result[idx*CHUNK +: CHUNK] = s[CHUNK-1:0]; carry <= s[CHUNK]; shift A and B right by CHUNK; idx <= idx+1.
  - On the edge where idx == NCH-1: also write result[N+1] = s[CHUNK] and go to DONE.
- DONE:
  - out_valid = 1; result is stable and unchanged while out_ready = 0.
  - On out_valid && out_ready: go to IDLE, out_valid drops on that edge.
  - result keeps its last value in IDLE.
- Latency:
  - Accept at edge 0 → out_valid is high after edge NCH (4 cycles at default).
  - With out_ready tied high, minimum issue period is NCH+2 cycles: DONE → IDLE handshake edge, then the next accept edge.
- No bypass: in_ready stays 0 in DONE even when out_ready = 1.
- in_valid is ignored while BUSY or DONE; the producer must hold it until accepted.
- Reset mid-operation (BUSY or DONE): transaction is aborted immediately, outputs return to reset values, and no out_valid pulse is produced.
- The first accept is possible at the first rising edge after rst deasserts.
- All arithmetic is unsigned. result width N+2 covers the maximum 2*(2^(N+1)-1)+1.

Test Plan:
1. N=15, CHUNK=4: sum_in=10, carry_in=0, cin=0 → out_valid 4 cycles after accept, result=10.
2. sum_in=0xFFFF, carry_in=0xFFFF, cin=1 → result=0x1FFFF (131071); the carry ripples through all 4 chunks and sets result[16].
3. sum_in=0x000F, carry_in=0x0001, cin=0 → result=0x0010 (chunk-boundary carry). Then 0x0FFF + 0x0001 → 0x1000.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, result stays constant, in_ready stays 0.
   - A second in_valid during this time is not accepted until after the handshake.
5. Reset mid-operation:
   - Assert rst asynchronously 2 cycles into BUSY → out_valid=0 and result=0 immediately, in_ready=0 during rst, in_ready=1 after release.
   - Next transaction 7+9, cin=1 → result=17.
6. Throughput: out_ready=1 and in_valid=1 continuously with 50 random operand triples → accepts every 6 cycles, each result equals sum_in+carry_in+cin computed by a scoreboard.
